// File: rtl/debug_command_parser.sv
// ASCII hex command parser between uart_rx and the PID core / autotuner / debug_output.
// Accepts <letter>[4 hex]<CR|LF> and drives registered control values and one-cycle request pulses.
module debug_command_parser #(
    parameter logic [15:0] KP_DEFAULT       = 16'h0100,
    parameter logic [15:0] KI_DEFAULT       = 16'h0010,
    parameter logic [15:0] KD_DEFAULT       = 16'h0000,
    parameter logic [15:0] SETPOINT_DEFAULT = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES   = 2_700_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_char,
    input  logic        tuning_busy,
    input  logic        tuned_valid,
    input  logic [15:0] tuned_kp,
    input  logic [15:0] tuned_ki,
    input  logic [15:0] tuned_kd,
    output logic [15:0] setpoint,
    output logic [15:0] kp,
    output logic [15:0] ki,
    output logic [15:0] kd,
    output logic        sim_mode,
    output logic        send_telemetry,
    output logic        tune_start,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [2:0]  err_code
);

    localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GET_HEX, WAIT_EOL, DISCARD} state_t;
    typedef enum logic [2:0] {CMD_S, CMD_P, CMD_I, CMD_D, CMD_M, CMD_T, CMD_A} cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d, letter_cmd;
    logic [15:0]   acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;

    logic [15:0] setpoint_d, kp_d, ki_d, kd_d;
    logic        sim_mode_d, send_telemetry_d, tune_start_d, cmd_ok_d, cmd_err_d;
    logic [2:0]  err_code_d;

    logic        is_eol, hex_ok, letter_ok, timeout;
    logic [3:0]  hex_nib;
    logic [7:0]  upper;

    always_comb begin
        is_eol  = (rx_char == 8'h0D) || (rx_char == 8'h0A);
        hex_ok  = 1'b1;
        hex_nib = '0;
        if (rx_char >= "0" && rx_char <= "9")      hex_nib = 4'(rx_char - 8'h30);
        else if (rx_char >= "A" && rx_char <= "F") hex_nib = 4'(rx_char - 8'h37);
        else if (rx_char >= "a" && rx_char <= "f") hex_nib = 4'(rx_char - 8'h57);
        else                                        hex_ok  = 1'b0;

        // Clearing bit 5 folds lower-case letters onto upper-case; no non-letter maps onto a command letter.
        upper      = rx_char & 8'hDF;
        letter_ok  = 1'b1;
        letter_cmd = CMD_S;
        case (upper)
            "S":     letter_cmd = CMD_S;
            "P":     letter_cmd = CMD_P;
            "I":     letter_cmd = CMD_I;
            "D":     letter_cmd = CMD_D;
            "M":     letter_cmd = CMD_M;
            "T":     letter_cmd = CMD_T;
            "A":     letter_cmd = CMD_A;
            default: letter_ok  = 1'b0;
        endcase

        timeout = !rx_valid && (state_q != IDLE) && (gap_q == GAP_LIMIT - GW'(1));
    end

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        gap_d            = rx_valid ? '0 : ((gap_q == GAP_LIMIT) ? gap_q : gap_q + GW'(1));
        setpoint_d       = setpoint;
        kp_d             = kp;
        ki_d             = ki;
        kd_d             = kd;
        sim_mode_d       = sim_mode;
        send_telemetry_d = 1'b0;
        tune_start_d     = 1'b0;
        cmd_ok_d         = 1'b0;
        cmd_err_d        = 1'b0;
        err_code_d       = err_code;

        if (tuned_valid) begin
            kp_d = tuned_kp;
            ki_d = tuned_ki;
            kd_d = tuned_kd;
        end

        if (timeout) begin
            cmd_err_d  = 1'b1;
            err_code_d = 3'd4;
            state_d    = IDLE;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (!is_eol) begin
                        if (letter_ok) begin
                            cmd_d   = letter_cmd;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = (letter_cmd == CMD_T || letter_cmd == CMD_A) ? WAIT_EOL : GET_HEX;
                        end else begin
                            cmd_err_d  = 1'b1;
                            err_code_d = 3'd1;
                            state_d    = DISCARD;
                        end
                    end
                end
                GET_HEX: begin
                    if (hex_ok) begin
                        acc_d = {acc_q[11:0], hex_nib};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd3) state_d = WAIT_EOL;
                    end else if (is_eol) begin
                        cmd_err_d  = 1'b1;
                        err_code_d = 3'd2;
                        state_d    = IDLE;
                    end else begin
                        cmd_err_d  = 1'b1;
                        err_code_d = 3'd3;
                        state_d    = DISCARD;
                    end
                end
                WAIT_EOL: begin
                    if (is_eol) begin
                        state_d  = IDLE;
                        cmd_ok_d = 1'b1;
                        case (cmd_q)
                            CMD_S: setpoint_d = acc_q;
                            CMD_P, CMD_I, CMD_D: begin
                                // A coincident tuned_valid owns the gain registers this cycle.
                                if (tuning_busy || tuned_valid) begin
                                    cmd_ok_d  = 1'b0;
                                    cmd_err_d = 1'b1;
                                end else if (cmd_q == CMD_P) kp_d = acc_q;
                                else if (cmd_q == CMD_I)     ki_d = acc_q;
                                else                         kd_d = acc_q;
                                if (cmd_err_d) err_code_d = 3'd6;
                            end
                            CMD_M: begin
                                if (acc_q > 16'd1) begin
                                    cmd_ok_d   = 1'b0;
                                    cmd_err_d  = 1'b1;
                                    err_code_d = 3'd5;
                                end else sim_mode_d = acc_q[0];
                            end
                            CMD_T: send_telemetry_d = 1'b1;
                            CMD_A: begin
                                if (tuning_busy) begin
                                    cmd_ok_d   = 1'b0;
                                    cmd_err_d  = 1'b1;
                                    err_code_d = 3'd6;
                                end else tune_start_d = 1'b1;
                            end
                            default: cmd_ok_d = 1'b0;
                        endcase
                        if (cmd_ok_d) err_code_d = '0;
                    end else begin
                        cmd_err_d  = 1'b1;
                        err_code_d = 3'd2;
                        state_d    = DISCARD;
                    end
                end
                DISCARD: if (is_eol) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cmd_q          <= CMD_S;
            acc_q          <= '0;
            cnt_q          <= '0;
            gap_q          <= '0;
            setpoint       <= SETPOINT_DEFAULT;
            kp             <= KP_DEFAULT;
            ki             <= KI_DEFAULT;
            kd             <= KD_DEFAULT;
            sim_mode       <= 1'b0;
            send_telemetry <= 1'b0;
            tune_start     <= 1'b0;
            cmd_ok         <= 1'b0;
            cmd_err        <= 1'b0;
            err_code       <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            gap_q          <= gap_d;
            setpoint       <= setpoint_d;
            kp             <= kp_d;
            ki             <= ki_d;
            kd             <= kd_d;
            sim_mode       <= sim_mode_d;
            send_telemetry <= send_telemetry_d;
            tune_start     <= tune_start_d;
            cmd_ok         <= cmd_ok_d;
            cmd_err        <= cmd_err_d;
            err_code       <= err_code_d;
        end
    end

endmodule

// File: tb/tb_debug_command_parser.sv
// Bench for debug_command_parser: directed command lines plus random byte streams,
// checked every cycle against a line-buffer model of the command grammar.
module tb_debug_command_parser;

    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_char = '0;
    logic        tuning_busy = 1'b0;
    logic        tuned_valid = 1'b0;
    logic [15:0] tuned_kp = '0, tuned_ki = '0, tuned_kd = '0;
    logic [15:0] setpoint, kp, ki, kd;
    logic        sim_mode, send_telemetry, tune_start, cmd_ok, cmd_err;
    logic [2:0]  err_code;

    debug_command_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_char(rx_char),
        .tuning_busy(tuning_busy), .tuned_valid(tuned_valid),
        .tuned_kp(tuned_kp), .tuned_ki(tuned_ki), .tuned_kd(tuned_kd),
        .setpoint(setpoint), .kp(kp), .ki(ki), .kd(kd), .sim_mode(sim_mode),
        .send_telemetry(send_telemetry), .tune_start(tune_start),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: bytes of the current line are buffered and judged against the grammar.
    logic [15:0] m_sp, m_kp, m_ki, m_kd;
    logic        m_sim, m_tel, m_tune, m_ok, m_err;
    logic [2:0]  m_code;
    logic [7:0]  lb[$];
    bit          disc;
    int unsigned gap;

    function automatic logic [7:0] upcase(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic bit is_arg(input logic [7:0] l);
        return l == "S" || l == "P" || l == "I" || l == "D" || l == "M";
    endfunction

    function automatic bit is_eol(input logic [7:0] b);
        return b == 8'h0D || b == 8'h0A;
    endfunction

    task automatic m_fail(input int c);
        m_err  = 1'b1;
        m_code = 3'(c);
    endtask

    task automatic m_pass();
        m_ok   = 1'b1;
        m_code = '0;
    endtask

    task automatic m_exec();
        logic [7:0]  l;
        int unsigned val;
        l   = upcase(lb[0]);
        val = 0;
        for (int i = 1; i < lb.size(); i++) val = val * 16 + hexval(lb[i]);
        if (l == "S") begin
            m_sp = 16'(val); m_pass();
        end else if (l == "P" || l == "I" || l == "D") begin
            if (tuning_busy || tuned_valid) m_fail(6);
            else begin
                if (l == "P") m_kp = 16'(val);
                if (l == "I") m_ki = 16'(val);
                if (l == "D") m_kd = 16'(val);
                m_pass();
            end
        end else if (l == "M") begin
            if (val > 1) m_fail(5);
            else begin m_sim = (val == 1); m_pass(); end
        end else if (l == "T") begin
            m_tel = 1'b1; m_pass();
        end else begin
            if (tuning_busy) m_fail(6);
            else begin m_tune = 1'b1; m_pass(); end
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        m_tel = 0; m_tune = 0; m_ok = 0; m_err = 0;
        if (tuned_valid) begin m_kp = tuned_kp; m_ki = tuned_ki; m_kd = tuned_kd; end
        if (!v) begin
            if (gap < TO) begin
                gap++;
                if (gap == TO && (lb.size() > 0 || disc)) begin
                    m_fail(4); lb.delete(); disc = 0;
                end
            end
            return;
        end
        gap = 0;
        if (is_eol(b)) begin
            if (disc) disc = 0;
            else if (lb.size() > 0) begin
                if (is_arg(upcase(lb[0])) && lb.size() < 5) m_fail(2);
                else m_exec();
                lb.delete();
            end
        end else if (!disc) begin
            if (lb.size() == 0) begin
                if (is_arg(upcase(b)) || upcase(b) == "T" || upcase(b) == "A") lb.push_back(b);
                else begin m_fail(1); disc = 1; end
            end else if (!is_arg(upcase(lb[0])) || lb.size() == 5) begin
                m_fail(2); disc = 1; lb.delete();
            end else if (hexval(b) >= 0) lb.push_back(b);
            else begin m_fail(3); disc = 1; lb.delete(); end
        end
    endtask

    task automatic compare_all();
        check("setpoint", setpoint, m_sp);
        check("kp", kp, m_kp);
        check("ki", ki, m_ki);
        check("kd", kd, m_kd);
        check("sim_mode", 16'(sim_mode), 16'(m_sim));
        check("send_telemetry", 16'(send_telemetry), 16'(m_tel));
        check("tune_start", 16'(tune_start), 16'(m_tune));
        check("cmd_ok", 16'(cmd_ok), 16'(m_ok));
        check("cmd_err", 16'(cmd_err), 16'(m_err));
        check("err_code", 16'(err_code), 16'(m_code));
        check("ok_and_err", 16'(cmd_ok & cmd_err), 16'h0000);
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_char  = b;
        model_step(v, b);
        @(posedge clk);
        #1;
        compare_all();
        rx_valid    = 1'b0;
        tuned_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        tuned_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_sp = 16'h0000; m_kp = 16'h0100; m_ki = 16'h0010; m_kd = 16'h0000;
        m_sim = 0; m_tel = 0; m_tune = 0; m_ok = 0; m_err = 0; m_code = '0;
        lb.delete(); disc = 0; gap = 0;
        compare_all();
    endtask

    task automatic put(input logic [7:0] b, input int unsigned g);
        step(1'b1, b);
        repeat (g) step(1'b0, 8'h00);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i], 0);
    endtask

    initial begin
        string lt, hx;
        logic [7:0] c, l;
        int unsigned nd, r;

        do_reset();
        check("reset_kp", kp, 16'h0100);
        check("reset_ki", ki, 16'h0010);

        send("P01A3\r");
        check("plan_kp", kp, 16'h01A3);
        send("s00ff\n");
        check("plan_setpoint", setpoint, 16'h00FF);
        send("T\r");
        tuning_busy = 1'b1;
        send("A\n");
        check("plan_busy_code", 16'(err_code), 16'd6);
        tuning_busy = 1'b0;
        send("X12\rS12\r");
        check("plan_sp_kept", setpoint, 16'h00FF);
        send("M0002\r");
        check("plan_sim_kept", 16'(sim_mode), 16'd0);
        send("M0001\r");
        check("plan_sim_set", 16'(sim_mode), 16'd1);
        send("D12G4\r");
        check("plan_kd_kept", kd, 16'h0000);
        send("I00");
        repeat (TO + 3) step(1'b0, 8'h00);
        send("I0040\r");
        check("plan_ki", ki, 16'h0040);
        send("P0111");
        tuned_kp = 16'h0222; tuned_ki = 16'h0333; tuned_kd = 16'h0444;
        tuned_valid = 1'b1;
        step(1'b1, 8'h0D);
        check("plan_tuned_kp", kp, 16'h0222);
        check("plan_tuned_code", 16'(err_code), 16'd6);
        send("S12");
        do_reset();
        send("P12");
        put("3", TO - 1);
        put("4", TO);
        send("\r");

        lt = "SPIDMTAspidmtaXz#3";
        hx = "0123456789abcdefABCDEFG/ ";
        for (int n = 0; n < 600; n++) begin
            tuning_busy = ($urandom_range(0, 3) == 0);
            l = lt[$urandom_range(0, lt.len() - 1)];
            if (upcase(l) == "T" || upcase(l) == "A") nd = ($urandom_range(0, 5) == 0) ? 1 : 0;
            else nd = ($urandom_range(0, 9) < 7) ? 4 : $urandom_range(0, 5);
            for (int k = 0; k <= nd + 1; k++) begin
                if (k == 0) c = l;
                else if (k == nd + 1) c = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
                else if (upcase(l) == "M" && $urandom_range(0, 1) == 1) c = (k < 4) ? "0" : 8'(48 + $urandom_range(0, 2));
                else c = hx[$urandom_range(0, hx.len() - 1)];
                if ($urandom_range(0, 19) == 0) begin
                    tuned_valid = 1'b1;
                    tuned_kp = 16'($urandom); tuned_ki = 16'($urandom); tuned_kd = 16'($urandom);
                end
                r = $urandom_range(0, 59);
                put(c, (r == 0) ? TO - 1 : (r == 1) ? TO : (r == 2) ? TO + 3 : $urandom_range(0, 2));
                if ($urandom_range(0, 299) == 0) do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
